// File: rtl/forward_ctrl.sv
// rtl/forward_ctrl.sv - EX operand forwarding select and load-use hazard controller
module forward_ctrl #(
  parameter int RegBits = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Freeze,
  input  logic               Flush,
  input  logic [RegBits-1:0] ID_Rs,
  input  logic [RegBits-1:0] ID_Rt,
  input  logic               ID_UsesRs,
  input  logic               ID_UsesRt,
  input  logic [RegBits-1:0] ID_Rd,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  output logic [1:0]         ForwardA,
  output logic [1:0]         ForwardB,
  output logic               LoadUseStall
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  // Destination tags of the instructions currently in EX and MEM
  logic [RegBits-1:0] ex_rd;
  logic               ex_regwrite;
  logic               ex_memread;
  logic [RegBits-1:0] mem_rd;
  logic               mem_regwrite;

  logic               hit_rs;
  logic               hit_rt;
  logic [1:0]         sel_a;
  logic [1:0]         sel_b;
  logic               bubble;

  // Youngest matching producer wins; r0 and unused operands always read the register file
  function automatic logic [1:0] select_for(
    input logic [RegBits-1:0] src,
    input logic               uses,
    input logic [RegBits-1:0] e_rd,
    input logic               e_wr,
    input logic [RegBits-1:0] m_rd,
    input logic               m_wr
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (uses && (src != '0)) begin
      if (e_wr && (e_rd == src)) begin
        sel = SEL_EXMEM;
      end else if (m_wr && (m_rd == src)) begin
        sel = SEL_MEMWB;
      end
    end
    return sel;
  endfunction

  // Load in EX whose result an ID operand needs: stall one cycle
  always_comb begin
    hit_rs       = (ID_Rs != '0) && ex_regwrite && ex_memread && (ex_rd == ID_Rs);
    hit_rt       = (ID_Rt != '0) && ex_regwrite && ex_memread && (ex_rd == ID_Rt);
    LoadUseStall = (hit_rs && ID_UsesRs) || (hit_rt && ID_UsesRt);
    bubble       = Flush || LoadUseStall;
  end

  // Selects for the ID instruction, from the tags as they stand before the advance
  always_comb begin
    sel_a = select_for(ID_Rs, ID_UsesRs, ex_rd, ex_regwrite, mem_rd, mem_regwrite);
    sel_b = select_for(ID_Rt, ID_UsesRt, ex_rd, ex_regwrite, mem_rd, mem_regwrite);
  end

  // Advance the tag pipeline and register the selects; Freeze holds everything
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ex_rd        <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      ForwardA     <= SEL_RF;
      ForwardB     <= SEL_RF;
    end else if (!Freeze) begin
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      if (bubble) begin
        ex_rd       <= '0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ForwardA    <= SEL_RF;
        ForwardB    <= SEL_RF;
      end else begin
        ex_rd       <= ID_Rd;
        ex_regwrite <= ID_RegWrite;
        ex_memread  <= ID_MemRead;
        ForwardA    <= sel_a;
        ForwardB    <= sel_b;
      end
    end
  end

endmodule

// File: tb/tb_forward_ctrl.sv
// tb/tb_forward_ctrl.sv - self-checking bench for forward_ctrl
module tb_forward_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Freeze = 1'b0;
  logic       Flush = 1'b0;
  logic [4:0] ID_Rs = '0;
  logic [4:0] ID_Rt = '0;
  logic       ID_UsesRs = 1'b0;
  logic       ID_UsesRt = 1'b0;
  logic [4:0] ID_Rd = '0;
  logic       ID_RegWrite = 1'b0;
  logic       ID_MemRead = 1'b0;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;
  logic       LoadUseStall;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic chk_en = 1'b0;

  forward_ctrl #(.RegBits(5)) dut (
    .Clk(Clk), .Reset(Reset), .Freeze(Freeze), .Flush(Flush),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_Rd(ID_Rd), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .LoadUseStall(LoadUseStall)
  );

  always #5 Clk = ~Clk;

  // Reference model: occupants of EX (index 0) and MEM (index 1), youngest first
  typedef struct {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } instr_t;

  instr_t     stage [2];
  logic [1:0] m_fa = 2'b00;
  logic [1:0] m_fb = 2'b00;

  function automatic logic [1:0] m_fwd(input logic [4:0] r, input logic uses);
    if (!uses || r == 0) return 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (stage[i].wr && stage[i].rd == r) return 2'(i + 1);
    end
    return 2'b00;
  endfunction

  function automatic logic m_stall();
    logic hazard_rs;
    logic hazard_rt;
    if (!(stage[0].wr && stage[0].ld)) return 1'b0;
    hazard_rs = ID_UsesRs && ID_Rs != 0 && ID_Rs == stage[0].rd;
    hazard_rt = ID_UsesRt && ID_Rt != 0 && ID_Rt == stage[0].rd;
    return hazard_rs || hazard_rt;
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stage[0] = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};
      stage[1] = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};
      m_fa = 2'b00;
      m_fb = 2'b00;
    end else if (!Freeze) begin
      if (Flush || m_stall()) begin
        stage[1] = stage[0];
        stage[0] = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};
        m_fa = 2'b00;
        m_fb = 2'b00;
      end else begin
        m_fa = m_fwd(ID_Rs, ID_UsesRs);
        m_fb = m_fwd(ID_Rt, ID_UsesRt);
        stage[1] = stage[0];
        stage[0] = '{rd: ID_Rd, wr: ID_RegWrite, ld: ID_MemRead};
      end
    end
  end

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Every cycle, away from the clock edge: DUT against model
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("model_fwd_a", ForwardA, m_fa);
      chk("model_fwd_b", ForwardB, m_fb);
      chk("model_stall", {1'b0, LoadUseStall}, {1'b0, m_stall()});
    end
  end

  task automatic cyc();
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask

  task automatic ins(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                     input logic [4:0] rd, input logic rw, input logic mr);
    ID_Rs = rs; ID_Rt = rt; ID_UsesRs = urs; ID_UsesRt = urt;
    ID_Rd = rd; ID_RegWrite = rw; ID_MemRead = mr;
  endtask

  task automatic nop();
    ins(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0] held_a;
    logic [1:0] held_b;
    #1 Reset = 1'b0;
    #1 chk_en = 1'b1;
    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      ins(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      Flush = 1'($urandom);
      cyc();
      chk("rst_fa", ForwardA, 2'b00);
      chk("rst_fb", ForwardB, 2'b00);
      chk("rst_stall", {1'b0, LoadUseStall}, 2'b00);
    end
    Flush = 1'b0;
    nop();
    Reset = 1'b1;
    cyc();
    chk("post_rst_fa", ForwardA, 2'b00);
    chk("post_rst_fb", ForwardB, 2'b00);

    // EX/MEM forward: add r3 ; sub rs=3
    ins(5'd1, 5'd2, 1, 1, 5'd3, 1, 0); cyc();
    ins(5'd3, 5'd4, 1, 1, 5'd6, 1, 0); cyc();
    chk("exmem_fa", ForwardA, 2'b01);
    chk("exmem_fb", ForwardB, 2'b00);

    // MEM/WB forward: add r3 ; independent ; rt=3
    ins(5'd0, 5'd0, 0, 0, 5'd3, 1, 0); cyc();
    ins(5'd1, 5'd2, 1, 1, 5'd7, 1, 0); cyc();
    ins(5'd1, 5'd3, 1, 1, 5'd8, 1, 0); cyc();
    chk("memwb_fb", ForwardB, 2'b10);
    chk("memwb_fa", ForwardA, 2'b00);

    // Two writers of r3 then a reader: youngest wins
    ins(5'd0, 5'd0, 0, 0, 5'd3, 1, 0); cyc();
    ins(5'd0, 5'd0, 0, 0, 5'd3, 1, 0); cyc();
    ins(5'd3, 5'd3, 1, 1, 5'd9, 1, 0); cyc();
    chk("prio_fa", ForwardA, 2'b01);
    chk("prio_fb", ForwardB, 2'b01);

    // Load-use: lw r5 ; reader rs=5
    ins(5'd0, 5'd0, 0, 0, 5'd5, 1, 1); cyc();
    ins(5'd5, 5'd1, 1, 1, 5'd9, 1, 0); #1;
    chk("lu_stall_on", {1'b0, LoadUseStall}, 2'b01);
    cyc();
    chk("lu_bubble_fa", ForwardA, 2'b00);
    chk("lu_bubble_fb", ForwardB, 2'b00);
    chk("lu_stall_off", {1'b0, LoadUseStall}, 2'b00);
    cyc();
    chk("lu_memwb_fa", ForwardA, 2'b10);

    // r0 never forwarded
    ins(5'd0, 5'd0, 0, 0, 5'd0, 1, 0); cyc();
    ins(5'd0, 5'd0, 1, 1, 5'd2, 1, 0); cyc();
    chk("r0_fa", ForwardA, 2'b00);
    chk("r0_fb", ForwardB, 2'b00);

    // UsesRt=0 masks both forward and stall
    ins(5'd0, 5'd0, 0, 0, 5'd6, 1, 1); cyc();
    ins(5'd1, 5'd6, 1, 0, 5'd2, 1, 0); #1;
    chk("mask_stall", {1'b0, LoadUseStall}, 2'b00);
    cyc();
    chk("mask_fb", ForwardB, 2'b00);

    // Freeze for 3 cycles mid-sequence
    ins(5'd0, 5'd0, 0, 0, 5'd4, 1, 0); cyc();
    ins(5'd4, 5'd0, 1, 0, 5'd10, 1, 0); cyc();
    chk("frz_pre_fa", ForwardA, 2'b01);
    held_a = ForwardA;
    held_b = ForwardB;
    Freeze = 1'b1;
    ins(5'd4, 5'd10, 1, 1, 5'd11, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("frz_hold_fa", ForwardA, held_a);
      chk("frz_hold_fb", ForwardB, held_b);
    end
    Freeze = 1'b0;
    cyc();
    chk("frz_resume_fa", ForwardA, 2'b10);
    chk("frz_resume_fb", ForwardB, 2'b01);

    // Stall visible during Freeze, bubble only after release
    ins(5'd0, 5'd0, 0, 0, 5'd12, 1, 1); cyc();
    Freeze = 1'b1;
    ins(5'd12, 5'd0, 1, 0, 5'd13, 1, 0);
    cyc(); cyc();
    chk("frz_stall", {1'b0, LoadUseStall}, 2'b01);
    Freeze = 1'b0;
    cyc();
    chk("frz_lu_bubble", ForwardA, 2'b00);
    cyc();
    chk("frz_lu_memwb", ForwardA, 2'b10);

    // Flush with a matching ID instruction; the bubble forwards nothing later
    ins(5'd0, 5'd0, 0, 0, 5'd13, 1, 0); cyc();
    Flush = 1'b1;
    ins(5'd13, 5'd13, 1, 1, 5'd14, 1, 0); cyc();
    chk("flush_fa", ForwardA, 2'b00);
    chk("flush_fb", ForwardB, 2'b00);
    Flush = 1'b0;
    ins(5'd14, 5'd14, 1, 1, 5'd1, 1, 0); cyc();
    chk("flush_nofwd_fa", ForwardA, 2'b00);
    chk("flush_nofwd_fb", ForwardB, 2'b00);

    // Flush and stall together: one bubble
    ins(5'd0, 5'd0, 0, 0, 5'd15, 1, 1); cyc();
    Flush = 1'b1;
    ins(5'd15, 5'd0, 1, 0, 5'd2, 1, 0); #1;
    chk("fl_lu_stall", {1'b0, LoadUseStall}, 2'b01);
    cyc();
    Flush = 1'b0;
    chk("fl_lu_bubble", ForwardA, 2'b00);
    cyc();
    chk("fl_lu_memwb", ForwardA, 2'b10);

    // Reset mid-stall clears the stall immediately
    ins(5'd0, 5'd0, 0, 0, 5'd16, 1, 1); cyc();
    ins(5'd16, 5'd0, 1, 0, 5'd2, 1, 0); #1;
    chk("mid_rst_pre", {1'b0, LoadUseStall}, 2'b01);
    Reset = 1'b0; #1;
    chk("mid_rst_stall", {1'b0, LoadUseStall}, 2'b00);
    cyc();
    Reset = 1'b1;
    nop();
    cyc(); cyc();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/forward_ctrl.md
# forward_ctrl

Sequential operand-forwarding controller for the 5-stage pipeline. It tracks the destination tags of the instructions in the EX and MEM stages. On every pipeline advance it registers the 2-bit select codes that steer the two EX-stage operand 3-input selectors, and it detects load-use hazards. It sits directly upstream of the EX operand selectors. Its `ForwardA`/`ForwardB` outputs drive those selectors' `Sel` inputs.

## Interface

Parameters:
- `RegBits`, default 5: register-address width.

Ports:
- `Clk`, input, 1: the single clock. All state is rising-edge.
- `Reset`, input, 1: asynchronous, active-low reset.
- `Freeze`, input, 1: global hold. No tag or output register changes.
- `Flush`, input, 1: insert a bubble into EX on the next advance (taken branch).
- `ID_Rs`, input, RegBits: source register A of the instruction in ID.
- `ID_Rt`, input, RegBits: source register B of the instruction in ID.
- `ID_UsesRs`, input, 1: the ID instruction reads Rs.
- `ID_UsesRt`, input, 1: the ID instruction reads Rt.
- `ID_Rd`, input, RegBits: destination register of the ID instruction.
- `ID_RegWrite`, input, 1: the ID instruction writes `ID_Rd`.
- `ID_MemRead`, input, 1: the ID instruction is a load.
- `ForwardA`, output, 2: registered select for EX operand A.
- `ForwardB`, output, 2: registered select for EX operand B.
- `LoadUseStall`, output, 1: combinational. Hold PC/IF/ID and insert a bubble.

## Operation

- Select encoding, matching the operand selector:
  - 00: register-file value.
  - 01: EX/MEM result.
  - 10: MEM/WB result.
  - 11: never produced.
- Internal tag registers:
  - EX tag: {Rd, RegWrite, MemRead}.
  - MEM tag: {Rd, RegWrite}.
  - A bubble is a tag with RegWrite=0 and MemRead=0.
- Hazard detection:
  - Define `hit(r) = (r != 0) && EX.RegWrite && EX.MemRead && EX.Rd == r`.
  - `LoadUseStall = hit(ID_Rs)&&ID_UsesRs || hit(ID_Rt)&&ID_UsesRt`.
  - `LoadUseStall` is independent of `Freeze`.
- Advance edge (`Freeze`=0):
  - The MEM tag takes the old EX tag, always.
  - If `Flush` or `LoadUseStall` is 1: the EX tag becomes a bubble, and `ForwardA`/`ForwardB` become 00.
  - Otherwise: the EX tag takes {ID_Rd, ID_RegWrite, ID_MemRead}, and the selects are computed from the old EX and MEM tags.
- Select computation for operand A (operand B is identical with Rt/UsesRt):
  - 00 if `!ID_UsesRs || ID_Rs == 0`.
  - Else 01 if `EX.RegWrite && EX.Rd == ID_Rs`.
  - Else 10 if `MEM.RegWrite && MEM.Rd == ID_Rs`.
  - Else 00.
- Priority rules:
  - The youngest producer (01) wins when both stages match.
  - Register 0 is never forwarded.
- A load in EX that matches never yields 01: a stall is raised instead. After the bubble, the load is in MEM, and the dependent instruction gets 10 on its advance.
- WB-stage to ID same-cycle hazards are not handled here. The register file provides write-before-read.
- Control priority:
  1. `Reset`.
  2. `Freeze`: hold everything, including the selects.
  3. `Flush`/`LoadUseStall`: bubble.
  4. Normal advance.

## Timing

- Reset (asynchronous assert, synchronous release):
  - Both tags become bubbles.
  - `ForwardA` = `ForwardB` = 00.
  - `LoadUseStall` = 0, because the EX tag is clear.
- Latency:
  - The selects are computed from ID-stage inputs and are valid the cycle after the advance edge, i.e. the same cycle the instruction occupies EX.
  - `LoadUseStall` has zero-cycle combinational latency from the ID inputs and the EX tag.
- A load-use stall lasts exactly one cycle per load: after the bubble, the EX tag's MemRead = 0.
- Freeze:
  - A frozen cycle leaves all outputs stable.
  - `LoadUseStall` may still assert during Freeze, but causes no bubble until Freeze drops.
- Flush and LoadUseStall in the same cycle produce a single bubble.
- Reset asserted mid-stall clears the stall the same instant it is asserted.

## Test plan

- **Reset:** hold `Reset`=0 with random inputs → ForwardA/B = 00 and LoadUseStall = 0, throughout and one cycle after release.
- **EX/MEM forward:**
  - Stimulus: issue `add r3` (RegWrite, Rd=3), then `sub` with Rs=3.
  - Required: ForwardA = 01 while `sub` is in EX; ForwardB = 00.
- **MEM/WB forward and priority:**
  - Stimulus 1: `add r3`, then an independent instruction, then Rt=3 → ForwardB = 10.
  - Stimulus 2: two back-to-back writers of r3, then a reader of r3 → 01, not 10.
- **Load-use:**
  - Stimulus: `lw r5` followed by a reader with Rs=5.
  - Required: LoadUseStall = 1 for exactly one cycle; the next EX selects are 00 (bubble); the dependent instruction then sees ForwardA = 10.
- **r0 and Uses masking:**
  - Stimulus 1: a writer of r0, then a reader of r0 → 00.
  - Stimulus 2: `ID_UsesRt`=0 with a matching Rt → ForwardB = 00 and no stall.
- **Freeze/Flush:**
  - Stimulus 1: Freeze for 3 cycles mid-sequence → outputs and tags unchanged, and the resumed sequence matches the unfrozen run.
  - Stimulus 2: Flush with a matching ID instruction → selects = 00 next cycle, and the bubble yields no later forward.
